// File: rtl/ibis_mapper_pkg.sv
// Shared types and constants for the ibis affine texture-address mapper.
package ibis_mapper_pkg;

   typedef enum logic [1:0] {
      MODE_STENCIL = 2'd0,
      MODE_WRAP    = 2'd1,
      MODE_CLAMP   = 2'd2
   } mode_t;

   // Bit positions inside the cfg_write strobe vector {MODE,TY,TX,D,C,B,A}
   localparam int unsigned CFG_A    = 0;
   localparam int unsigned CFG_B    = 1;
   localparam int unsigned CFG_C    = 2;
   localparam int unsigned CFG_D    = 3;
   localparam int unsigned CFG_TX   = 4;
   localparam int unsigned CFG_TY   = 5;
   localparam int unsigned CFG_MODE = 6;
   localparam int unsigned CFG_W    = 7;

   // Fixed-point 1.0 for a coefficient with frac_bits fractional bits
   function automatic int unsigned coef_one(input int unsigned frac_bits);
      return 32'd1 << frac_bits;
   endfunction

endpackage

// File: rtl/ibis_mapper_resolve.sv
// Per-axis resolve: in-tile test and field selection for stencil, wrap or clamp.
module ibis_mapper_resolve
   import ibis_mapper_pkg::*;
#(
   parameter int unsigned TILE_SIZE_POW2 = 5,
   parameter int unsigned SUM_W          = 24
) (
   input  logic signed [SUM_W-1:0]          w_i,
   input  mode_t                            mode_i,
   output logic        [TILE_SIZE_POW2-1:0] field_c_o,
   output logic                             inb_c_o
);

   logic neg;
   logic over;

   assign neg     = w_i[SUM_W-1];
   assign over    = ~neg & (|w_i[SUM_W-2:TILE_SIZE_POW2]);
   assign inb_c_o = ~neg & ~over;

   // Stencil and wrap both keep the low bits; only clamp saturates
   always_comb begin
      field_c_o = w_i[TILE_SIZE_POW2-1:0];
      if (mode_i == MODE_CLAMP) begin
         if (neg) begin
            field_c_o = '0;
         end else if (over) begin
            field_c_o = '1;
         end
      end
   end

endmodule

// File: rtl/ibis_affine_mapper.sv
// Four-stage affine mapper: (x,y) -> [A B;C D]*[x y] - [tx ty] resolved to a tile texel address.
module ibis_affine_mapper
   import ibis_mapper_pkg::*;
#(
   parameter int unsigned TILE_SIZE_POW2 = 5,
   parameter int unsigned WIDTH          = 10,
   parameter int unsigned COEF_WIDTH     = 12,
   parameter int unsigned FRAC_BITS      = 4
) (
   input  logic                           aclk,
   input  logic                           areset,
   input  logic [CFG_W-1:0]               cfg_write,
   input  logic signed [COEF_WIDTH-1:0]   cfg_a,
   input  logic signed [COEF_WIDTH-1:0]   cfg_b,
   input  logic signed [COEF_WIDTH-1:0]   cfg_c,
   input  logic signed [COEF_WIDTH-1:0]   cfg_d,
   input  logic [WIDTH-1:0]               cfg_tx,
   input  logic [WIDTH-1:0]               cfg_ty,
   input  logic [1:0]                     cfg_mode,
   input  logic                           cfg_commit,
   output logic                           cfg_busy,
   input  logic                           s_valid,
   output logic                           s_ready,
   input  logic [WIDTH-1:0]               s_x,
   input  logic [WIDTH-1:0]               s_y,
   output logic                           m_valid,
   input  logic                           m_ready,
   output logic [2*TILE_SIZE_POW2-1:0]    m_address,
   output logic                           m_stencil
);

   localparam int unsigned ADDR_W = 2 * TILE_SIZE_POW2;
   localparam int unsigned P_W    = COEF_WIDTH + WIDTH + 1;
   localparam int unsigned SUM_W  = P_W + 1;
   localparam logic signed [COEF_WIDTH-1:0] COEF_ONE = COEF_WIDTH'(coef_one(FRAC_BITS));

   typedef enum logic {ST_IDLE, ST_PENDING} busy_state_t;

   busy_state_t state_q, state_d;
   logic        load_active;

   logic signed [COEF_WIDTH-1:0] sh_a_q, sh_b_q, sh_c_q, sh_d_q;
   logic signed [COEF_WIDTH-1:0] act_a_q, act_b_q, act_c_q, act_d_q;
   logic [WIDTH-1:0]             sh_tx_q, sh_ty_q, act_tx_q, act_ty_q;
   mode_t                        sh_mode_q, act_mode_q;

   logic                     v1_q, v2_q, v3_q, v4_q;
   logic                     advance, accept, pipe_empty;
   logic [WIDTH-1:0]         x1_q, y1_q;
   logic signed [P_W-1:0]    x_ext, y_ext;
   logic signed [P_W-1:0]    p_ax_d, p_by_d, p_cx_d, p_dy_d;
   logic signed [P_W-1:0]    p_ax_q, p_by_q, p_cx_q, p_dy_q;
   logic signed [SUM_W-1:0]  tx_term, ty_term, u_sum, v_sum;
   logic signed [SUM_W-1:0]  u_w_d, v_w_d, u_w_q, v_w_q;
   logic [TILE_SIZE_POW2-1:0] field_u, field_v;
   logic                     inb_u, inb_v;
   logic [ADDR_W-1:0]        addr_d, addr_q;
   logic                     stencil_d, stencil_q;

   // Shadow configuration: written any cycle by individual strobes
   always_ff @(posedge aclk) begin
      if (areset) begin
         sh_a_q    <= COEF_ONE;
         sh_b_q    <= '0;
         sh_c_q    <= '0;
         sh_d_q    <= COEF_ONE;
         sh_tx_q   <= '0;
         sh_ty_q   <= '0;
         sh_mode_q <= MODE_STENCIL;
      end else begin
         if (cfg_write[CFG_A])    sh_a_q    <= cfg_a;
         if (cfg_write[CFG_B])    sh_b_q    <= cfg_b;
         if (cfg_write[CFG_C])    sh_c_q    <= cfg_c;
         if (cfg_write[CFG_D])    sh_d_q    <= cfg_d;
         if (cfg_write[CFG_TX])   sh_tx_q   <= cfg_tx;
         if (cfg_write[CFG_TY])   sh_ty_q   <= cfg_ty;
         if (cfg_write[CFG_MODE]) sh_mode_q <= mode_t'(cfg_mode);
      end
   end

   // Active configuration only changes while the pipeline is empty
   always_ff @(posedge aclk) begin
      if (areset) begin
         act_a_q    <= COEF_ONE;
         act_b_q    <= '0;
         act_c_q    <= '0;
         act_d_q    <= COEF_ONE;
         act_tx_q   <= '0;
         act_ty_q   <= '0;
         act_mode_q <= MODE_STENCIL;
      end else if (load_active) begin
         act_a_q    <= sh_a_q;
         act_b_q    <= sh_b_q;
         act_c_q    <= sh_c_q;
         act_d_q    <= sh_d_q;
         act_tx_q   <= sh_tx_q;
         act_ty_q   <= sh_ty_q;
         act_mode_q <= sh_mode_q;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Commit FSM: a repeated commit while pending is absorbed
   always_comb begin
      state_d     = state_q;
      load_active = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cfg_commit) state_d = ST_PENDING;
         end
         ST_PENDING: begin
            if (pipe_empty) begin
               state_d     = ST_IDLE;
               load_active = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign cfg_busy   = (state_q == ST_PENDING);
   assign pipe_empty = ~(v1_q | v2_q | v3_q | v4_q);
   assign advance    = ~v4_q | m_ready;
   assign s_ready    = ~areset & ~cfg_busy & advance;
   assign accept     = s_valid & s_ready;

   assign x_ext  = P_W'($signed({1'b0, x1_q}));
   assign y_ext  = P_W'($signed({1'b0, y1_q}));
   assign p_ax_d = P_W'(act_a_q) * x_ext;
   assign p_by_d = P_W'(act_b_q) * y_ext;
   assign p_cx_d = P_W'(act_c_q) * x_ext;
   assign p_dy_d = P_W'(act_d_q) * y_ext;

   // Translation is integer texels, aligned to the coefficient binary point
   assign tx_term = SUM_W'({act_tx_q, {FRAC_BITS{1'b0}}});
   assign ty_term = SUM_W'({act_ty_q, {FRAC_BITS{1'b0}}});
   assign u_sum   = SUM_W'(p_ax_q) + SUM_W'(p_by_q) - tx_term;
   assign v_sum   = SUM_W'(p_cx_q) + SUM_W'(p_dy_q) - ty_term;
   assign u_w_d   = u_sum >>> FRAC_BITS;
   assign v_w_d   = v_sum >>> FRAC_BITS;

   ibis_mapper_resolve #(.TILE_SIZE_POW2(TILE_SIZE_POW2), .SUM_W(SUM_W)) u_resolve_u (
      .w_i       (u_w_q),
      .mode_i    (act_mode_q),
      .field_c_o (field_u),
      .inb_c_o   (inb_u)
   );

   ibis_mapper_resolve #(.TILE_SIZE_POW2(TILE_SIZE_POW2), .SUM_W(SUM_W)) u_resolve_v (
      .w_i       (v_w_q),
      .mode_i    (act_mode_q),
      .field_c_o (field_v),
      .inb_c_o   (inb_v)
   );

   assign addr_d    = {field_v, field_u};
   assign stencil_d = inb_u & inb_v;

   // Linear pipeline under a single global stall
   always_ff @(posedge aclk) begin
      if (areset) begin
         v1_q      <= 1'b0;
         v2_q      <= 1'b0;
         v3_q      <= 1'b0;
         v4_q      <= 1'b0;
         x1_q      <= '0;
         y1_q      <= '0;
         p_ax_q    <= '0;
         p_by_q    <= '0;
         p_cx_q    <= '0;
         p_dy_q    <= '0;
         u_w_q     <= '0;
         v_w_q     <= '0;
         addr_q    <= '0;
         stencil_q <= 1'b0;
      end else if (advance) begin
         v1_q      <= accept;
         x1_q      <= s_x;
         y1_q      <= s_y;
         v2_q      <= v1_q;
         p_ax_q    <= p_ax_d;
         p_by_q    <= p_by_d;
         p_cx_q    <= p_cx_d;
         p_dy_q    <= p_dy_d;
         v3_q      <= v2_q;
         u_w_q     <= u_w_d;
         v_w_q     <= v_w_d;
         v4_q      <= v3_q;
         addr_q    <= addr_d;
         stencil_q <= stencil_d;
      end
   end

   assign m_valid   = v4_q;
   assign m_address = addr_q;
   assign m_stencil = stencil_q;

endmodule

// File: tb/tb_ibis_affine_mapper.sv
// Directed self-checking bench for ibis_affine_mapper.
module tb_ibis_affine_mapper;
   import ibis_mapper_pkg::*;

   localparam int unsigned TSP = 5;
   localparam int unsigned W   = 10;
   localparam int unsigned CW  = 12;
   localparam int unsigned FB  = 4;

   logic                 aclk = 1'b0;
   logic                 areset;
   logic [6:0]           cfg_write;
   logic signed [CW-1:0] cfg_a, cfg_b, cfg_c, cfg_d;
   logic [W-1:0]         cfg_tx, cfg_ty;
   logic [1:0]           cfg_mode;
   logic                 cfg_commit, cfg_busy;
   logic                 s_valid, s_ready;
   logic [W-1:0]         s_x, s_y;
   logic                 m_valid, m_ready;
   logic [2*TSP-1:0]     m_address;
   logic                 m_stencil;

   int errors = 0;
   int checks = 0;

   ibis_affine_mapper #(.TILE_SIZE_POW2(TSP), .WIDTH(W), .COEF_WIDTH(CW), .FRAC_BITS(FB)) dut (
      .aclk(aclk), .areset(areset), .cfg_write(cfg_write),
      .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_c(cfg_c), .cfg_d(cfg_d),
      .cfg_tx(cfg_tx), .cfg_ty(cfg_ty), .cfg_mode(cfg_mode),
      .cfg_commit(cfg_commit), .cfg_busy(cfg_busy),
      .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y),
      .m_valid(m_valid), .m_ready(m_ready), .m_address(m_address), .m_stencil(m_stencil)
   );

   always #5 aclk = ~aclk;

   task automatic tick;
      @(posedge aclk);
      #1;
   endtask

   task automatic set_cfg(input logic signed [CW-1:0] a, b, c, d,
                          input logic [W-1:0] tx, ty, input logic [1:0] mode);
      cfg_write = 7'h7f;
      cfg_a = a; cfg_b = b; cfg_c = c; cfg_d = d;
      cfg_tx = tx; cfg_ty = ty; cfg_mode = mode;
      cfg_commit = 1'b1;
      tick;
      cfg_write = '0;
      cfg_commit = 1'b0;
      for (int i = 0; i < 20 && cfg_busy; i++) tick;
      checks++;
      if (cfg_busy !== 1'b0) begin
         errors++;
         $display("FAIL cfg_commit_timeout busy=%b required=0", cfg_busy);
      end
   endtask

   task automatic send_one(input logic [W-1:0] x, y, output logic [2*TSP-1:0] addr, output logic st);
      int n;
      s_x = x; s_y = y; s_valid = 1'b1;
      #1;
      n = 0;
      while (!s_ready && n < 20) begin tick; n++; end
      tick;
      s_valid = 1'b0;
      n = 0;
      while (!m_valid && n < 20) begin tick; n++; end
      checks++;
      if (m_valid !== 1'b1) begin
         errors++;
         $display("FAIL send_timeout m_valid=%b required=1", m_valid);
      end
      addr = m_address;
      st   = m_stencil;
      tick;
   endtask

   task automatic test_reset;
      areset = 1'b1; m_ready = 1'b1; s_valid = 1'b0; s_x = '0; s_y = '0;
      cfg_write = '0; cfg_commit = 1'b0; cfg_a = '0; cfg_b = '0; cfg_c = '0; cfg_d = '0;
      cfg_tx = '0; cfg_ty = '0; cfg_mode = '0;
      tick; tick;
      checks++; if (m_valid !== 1'b0)   begin errors++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
      checks++; if (m_address !== '0)   begin errors++; $display("FAIL reset_m_address got=%0d exp=0", m_address); end
      checks++; if (m_stencil !== 1'b0) begin errors++; $display("FAIL reset_m_stencil got=%b exp=0", m_stencil); end
      checks++; if (cfg_busy !== 1'b0)  begin errors++; $display("FAIL reset_cfg_busy got=%b exp=0", cfg_busy); end
      checks++; if (s_ready !== 1'b0)   begin errors++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
      areset = 1'b0;
      #1;
      checks++; if (s_ready !== 1'b1)   begin errors++; $display("FAIL release_s_ready got=%b exp=1", s_ready); end
      tick;
   endtask

   task automatic test_identity;
      s_x = 10'd3; s_y = 10'd7; s_valid = 1'b1;
      #1;
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL ident_s_ready got=%b exp=1", s_ready); end
      tick;
      s_valid = 1'b0;
      tick; tick;
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ident_early_valid got=%b exp=0", m_valid); end
      tick;
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL ident_latency got=%b exp=1", m_valid); end
      checks++; if (m_address !== 10'd227) begin errors++; $display("FAIL ident_addr got=%0d exp=227", m_address); end
      checks++; if (m_stencil !== 1'b1) begin errors++; $display("FAIL ident_stencil got=%b exp=1", m_stencil); end
      tick;
   endtask

   task automatic test_translate;
      logic [2*TSP-1:0] a;
      logic s;
      logic [1:0]       modes [4]    = '{2'd0, 2'd1, 2'd2, 2'd3};
      logic [2*TSP-1:0] exp_addr [4] = '{10'd30, 10'd30, 10'd0, 10'd30};
      for (int i = 0; i < 4; i++) begin
         set_cfg(12'sd16, 12'sd0, 12'sd0, 12'sd16, 10'd5, 10'd0, modes[i]);
         send_one(10'd3, 10'd0, a, s);
         checks++; if (a !== exp_addr[i]) begin errors++; $display("FAIL tx_addr mode=%0d got=%0d exp=%0d", modes[i], a, exp_addr[i]); end
         checks++; if (s !== 1'b0) begin errors++; $display("FAIL tx_stencil mode=%0d got=%b exp=0", modes[i], s); end
      end
   endtask

   task automatic test_coef;
      logic [2*TSP-1:0] a;
      logic s;
      logic signed [CW-1:0] ca [8] = '{12'sd8, -12'sd16, 12'sd16, 12'sd16, -12'sd8, 12'sd0, 12'sd16, 12'sd16};
      logic signed [CW-1:0] cb [8] = '{12'sd0, 12'sd0, 12'sd0, 12'sd0, 12'sd0, 12'sd16, 12'sd0, 12'sd0};
      logic signed [CW-1:0] cc [8] = '{12'sd0, 12'sd0, 12'sd0, 12'sd0, 12'sd0, 12'sd16, 12'sd0, 12'sd0};
      logic signed [CW-1:0] cd [8] = '{12'sd16, 12'sd16, 12'sd16, 12'sd16, 12'sd16, 12'sd0, 12'sd16, 12'sd16};
      logic [W-1:0]     ty [8] = '{10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd2};
      logic [1:0]       md [8] = '{2'd0, 2'd2, 2'd2, 2'd1, 2'd0, 2'd0, 2'd2, 2'd1};
      logic [W-1:0]     vx [8] = '{10'd9, 10'd1, 10'd40, 10'd40, 10'd3, 10'd3, 10'd5, 10'd4};
      logic [W-1:0]     vy [8] = '{10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd7, 10'd100, 10'd1};
      logic [2*TSP-1:0] ea [8] = '{10'd4, 10'd0, 10'd31, 10'd8, 10'd30, 10'd103, 10'd997, 10'd996};
      logic             es [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 8; i++) begin
         set_cfg(ca[i], cb[i], cc[i], cd[i], 10'd0, ty[i], md[i]);
         send_one(vx[i], vy[i], a, s);
         checks++; if (a !== ea[i]) begin errors++; $display("FAIL coef_addr case=%0d got=%0d exp=%0d", i, a, ea[i]); end
         checks++; if (s !== es[i]) begin errors++; $display("FAIL coef_stencil case=%0d got=%b exp=%b", i, s, es[i]); end
      end
   endtask

   task automatic test_back_to_back;
      int sent, rcv, extra;
      logic [2*TSP-1:0] exp_a;
      set_cfg(12'sd16, 12'sd0, 12'sd0, 12'sd16, 10'd0, 10'd0, 2'd0);
      m_ready = 1'b0;
      sent = 0;
      for (int c = 0; c < 10; c++) begin
         s_valid = (sent < 8); s_x = W'(sent); s_y = W'(sent + 1);
         #1;
         if (s_valid && s_ready) sent++;
         tick;
      end
      s_valid = 1'b0;
      #1;
      checks++; if (sent != 4) begin errors++; $display("FAIL stall_accepted got=%0d exp=4", sent); end
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL stall_s_ready got=%b exp=0", s_ready); end
      checks++; if (m_valid !== 1'b1 || m_address !== 10'd32) begin
         errors++; $display("FAIL stall_hold valid=%b addr=%0d exp valid=1 addr=32", m_valid, m_address);
      end
      m_ready = 1'b1;
      rcv = 0;
      for (int c = 0; c < 60 && rcv < 8; c++) begin
         s_valid = (sent < 8); s_x = W'(sent); s_y = W'(sent + 1);
         #1;
         if (m_valid) begin
            exp_a = (2*TSP)'((rcv + 1) * 32 + rcv);
            checks++;
            if (m_address !== exp_a) begin errors++; $display("FAIL stream_addr beat=%0d got=%0d exp=%0d", rcv, m_address, exp_a); end
            rcv++;
         end
         if (s_valid && s_ready) sent++;
         tick;
      end
      s_valid = 1'b0;
      checks++; if (rcv != 8) begin errors++; $display("FAIL stream_count got=%0d exp=8", rcv); end
      extra = 0;
      for (int c = 0; c < 6; c++) begin
         if (m_valid) extra++;
         tick;
      end
      checks++; if (extra != 0) begin errors++; $display("FAIL stream_duplicates got=%0d exp=0", extra); end
   endtask

   task automatic test_commit_inflight;
      int rcv;
      logic [2*TSP-1:0] a;
      logic s;
      set_cfg(12'sd16, 12'sd0, 12'sd0, 12'sd16, 10'd0, 10'd0, 2'd0);
      for (int i = 0; i < 3; i++) begin
         s_x = W'(i + 1); s_y = '0; s_valid = 1'b1;
         tick;
      end
      s_valid = 1'b0;
      cfg_write = 7'b0000001; cfg_a = 12'sd32; cfg_commit = 1'b1;
      tick;
      cfg_write = '0; cfg_commit = 1'b0;
      checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL commit_busy got=%b exp=1", cfg_busy); end
      s_x = 10'd4; s_y = '0; s_valid = 1'b1;
      #1;
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL commit_s_ready got=%b exp=0", s_ready); end
      rcv = 0;
      for (int c = 0; c < 30; c++) begin
         if (m_valid) begin
            checks++;
            if (m_address !== (2*TSP)'(rcv + 1)) begin errors++; $display("FAIL commit_old_cfg beat=%0d got=%0d exp=%0d", rcv, m_address, rcv + 1); end
            rcv++;
         end
         if (s_ready) break;
         tick;
      end
      checks++; if (rcv != 3) begin errors++; $display("FAIL commit_drained got=%0d exp=3", rcv); end
      checks++; if (cfg_busy !== 1'b0 || s_ready !== 1'b1) begin
         errors++; $display("FAIL commit_release busy=%b s_ready=%b exp busy=0 s_ready=1", cfg_busy, s_ready);
      end
      s_valid = 1'b0;
      send_one(10'd4, 10'd0, a, s);
      checks++; if (a !== 10'd8) begin errors++; $display("FAIL commit_new_cfg got=%0d exp=8", a); end
   endtask

   task automatic test_reset_midflight;
      int extra;
      logic [2*TSP-1:0] a;
      logic s;
      for (int i = 0; i < 2; i++) begin
         s_x = W'(i + 1); s_y = '0; s_valid = 1'b1;
         tick;
      end
      s_valid = 1'b0;
      areset = 1'b1;
      tick;
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midreset_m_valid got=%b exp=0", m_valid); end
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL midreset_s_ready got=%b exp=0", s_ready); end
      areset = 1'b0;
      #1;
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL midreset_release got=%b exp=1", s_ready); end
      extra = 0;
      for (int c = 0; c < 6; c++) begin
         if (m_valid) extra++;
         tick;
      end
      checks++; if (extra != 0) begin errors++; $display("FAIL midreset_dropped got=%0d exp=0", extra); end
      send_one(10'd3, 10'd7, a, s);
      checks++; if (a !== 10'd227 || s !== 1'b1) begin
         errors++; $display("FAIL midreset_identity addr=%0d st=%b exp addr=227 st=1", a, s);
      end
   endtask

   initial begin
      test_reset;
      test_identity;
      test_translate;
      test_coef;
      test_back_to_back;
      test_commit_inflight;
      test_reset_midflight;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
